// File: rtl/clk_div_bank_if.sv
// Configuration write port of the clock divider bank: one write per strobe, reject pulse back.
interface clk_div_bank_if #(
  parameter int unsigned NUM_OUT = 7,
  parameter int unsigned CNT_W   = 8
);
  localparam int unsigned SEL_W = (NUM_OUT > 1) ? $clog2(NUM_OUT) : 1;

  logic             cfg_we;
  logic [SEL_W-1:0] cfg_sel;
  logic [CNT_W-1:0] cfg_divide;
  logic [CNT_W-1:0] cfg_high;
  logic [CNT_W-1:0] cfg_phase;
  logic             cfg_err;

  modport master (output cfg_we, cfg_sel, cfg_divide, cfg_high, cfg_phase, input  cfg_err);
  modport slave  (input  cfg_we, cfg_sel, cfg_divide, cfg_high, cfg_phase, output cfg_err);
endinterface

// File: rtl/clk_div_bank.sv
// Multi-output clock divider bank: per-channel divide/high/phase, glitch-free reconfiguration at
// each channel's period boundary, phase-coherent realign, and a settle/lock indicator.
module clk_div_bank #(
  parameter int unsigned NUM_OUT     = 7,
  parameter int unsigned CNT_W       = 8,
  parameter int unsigned DEF_DIVIDE  = 2,
  parameter int unsigned DEF_HIGH    = 1,
  parameter int unsigned LOCK_CYCLES = 16
) (
  input  logic                clk,
  input  logic                RST_N,
  input  logic                PWRDWN,
  input  logic                realign,
  clk_div_bank_if.slave       cfg,
  output logic [NUM_OUT-1:0]  CLKOUT,
  output logic                LOCKED
);
  localparam int unsigned SEL_W = (NUM_OUT > 1) ? $clog2(NUM_OUT) : 1;
  localparam int unsigned LC_W  = $clog2(LOCK_CYCLES + 1);

  typedef struct packed {
    logic [CNT_W-1:0] divide;
    logic [CNT_W-1:0] high;
    logic [CNT_W-1:0] phase;
  } ch_cfg_t;

  typedef enum logic [1:0] {ST_START, ST_DELAY, ST_RUN, ST_OFF} ch_state_t;

  localparam ch_cfg_t DEF_CFG = '{divide: CNT_W'(DEF_DIVIDE), high: CNT_W'(DEF_HIGH), phase: '0};

  logic               cfg_valid_c;
  logic               wr_ok_c;
  ch_cfg_t            wr_cfg_c;
  logic [NUM_OUT-1:0] run_c;
  logic [NUM_OUT-1:0] pend_c;

  // Write validation: channel in range and 2 <= D, 0 < H < D, P < D.
  always_comb begin
    wr_cfg_c    = '{divide: cfg.cfg_divide, high: cfg.cfg_high, phase: cfg.cfg_phase};
    cfg_valid_c = (32'(cfg.cfg_sel) < NUM_OUT) &&
                  (cfg.cfg_divide >= CNT_W'(2)) &&
                  (cfg.cfg_high != '0) &&
                  (cfg.cfg_high < cfg.cfg_divide) &&
                  (cfg.cfg_phase < cfg.cfg_divide);
    wr_ok_c     = cfg.cfg_we && cfg_valid_c;
  end

  for (genvar g = 0; g < NUM_OUT; g++) begin : g_ch
    ch_state_t        st_q, st_n;
    ch_cfg_t          act_q, act_n, shd_q, shd_n;
    logic [CNT_W-1:0] cnt_q, cnt_n, pc_q, pc_n;
    logic             pend_q, pend_n;
    logic             clk_q, clk_n;
    logic             hit_c;

    // Channel state register.
    always_ff @(posedge clk or negedge RST_N) begin
      if (!RST_N) begin
        st_q   <= ST_START;
        act_q  <= DEF_CFG;
        shd_q  <= DEF_CFG;
        cnt_q  <= '0;
        pc_q   <= '0;
        pend_q <= 1'b0;
        clk_q  <= 1'b0;
      end else begin
        st_q   <= st_n;
        act_q  <= act_n;
        shd_q  <= shd_n;
        cnt_q  <= cnt_n;
        pc_q   <= pc_n;
        pend_q <= pend_n;
        clk_q  <= clk_n;
      end
    end

    // Next state: power-down > realign > start/delay/run; START folds in the first phase compare
    // so that P=k makes the output rise on the (k+1)th edge after the start event.
    always_comb begin
      st_n   = st_q;
      act_n  = act_q;
      cnt_n  = cnt_q;
      pc_n   = pc_q;
      hit_c  = wr_ok_c && (cfg.cfg_sel == SEL_W'(g));
      shd_n  = hit_c ? wr_cfg_c : shd_q;
      pend_n = pend_q || hit_c;
      if (PWRDWN) begin
        st_n  = ST_OFF;
        cnt_n = '0;
        pc_n  = '0;
      end else if (realign) begin
        st_n   = ST_START;
        act_n  = shd_n;
        pend_n = 1'b0;
        cnt_n  = '0;
        pc_n   = '0;
      end else begin
        case (st_q)
          ST_START, ST_OFF: begin
            if (st_q == ST_OFF) begin
              act_n  = shd_n;
              pend_n = 1'b0;
            end
            cnt_n = '0;
            if (act_n.phase == '0) begin
              st_n = ST_RUN;
              pc_n = '0;
            end else begin
              st_n = ST_DELAY;
              pc_n = CNT_W'(1);
            end
          end
          ST_DELAY: begin
            if (pc_q == act_q.phase) begin
              st_n  = ST_RUN;
              cnt_n = '0;
            end else begin
              pc_n = pc_q + CNT_W'(1);
            end
          end
          ST_RUN: begin
            if (cnt_q == act_q.divide - CNT_W'(1)) begin
              cnt_n = '0;
              if (pend_n) begin
                act_n.divide = shd_n.divide;
                act_n.high   = shd_n.high;
                pend_n       = 1'b0;
              end
            end else begin
              cnt_n = cnt_q + CNT_W'(1);
            end
          end
          default: st_n = ST_START;
        endcase
      end
      clk_n = (st_n == ST_RUN) && (cnt_n < act_n.high);
    end

    assign CLKOUT[g] = clk_q;
    assign run_c[g]  = (st_q == ST_RUN);
    assign pend_c[g] = pend_q;
  end

  logic            clr_c;
  logic [LC_W-1:0] lc_q, lc_n;

  // Lock counter: counts settled cycles, restarts on any disturbance, saturates at LOCK_CYCLES.
  always_comb begin
    clr_c = wr_ok_c || realign || PWRDWN;
    lc_n  = '0;
    if (!clr_c && (&run_c) && !(|pend_c)) begin
      lc_n = (lc_q == LC_W'(LOCK_CYCLES)) ? lc_q : lc_q + LC_W'(1);
    end
  end

  // Lock and reject-pulse registers.
  always_ff @(posedge clk or negedge RST_N) begin
    if (!RST_N) begin
      lc_q        <= '0;
      LOCKED      <= 1'b0;
      cfg.cfg_err <= 1'b0;
    end else begin
      lc_q        <= lc_n;
      LOCKED      <= (lc_n == LC_W'(LOCK_CYCLES));
      cfg.cfg_err <= cfg.cfg_we && !cfg_valid_c;
    end
  end
endmodule

// File: tb/tb_clk_div_bank.sv
// Directed bench for clk_div_bank. NUM_OUT=5 so that the 3-bit cfg_sel can name a channel
// that does not exist; channels 0..3 carry the scenarios, channel 4 stays at defaults.
module tb_clk_div_bank;
  localparam int unsigned NUM_OUT = 5;
  localparam int unsigned CNT_W   = 8;

  logic               clk;
  logic               RST_N;
  logic               PWRDWN;
  logic               realign;
  logic [NUM_OUT-1:0] CLKOUT;
  logic               LOCKED;

  int total;
  int bad;
  int cyc;

  clk_div_bank_if #(.NUM_OUT(NUM_OUT), .CNT_W(CNT_W)) cfg ();

  clk_div_bank #(
    .NUM_OUT(NUM_OUT), .CNT_W(CNT_W), .DEF_DIVIDE(2), .DEF_HIGH(1), .LOCK_CYCLES(16)
  ) dut (
    .clk(clk), .RST_N(RST_N), .PWRDWN(PWRDWN), .realign(realign),
    .cfg(cfg), .CLKOUT(CLKOUT), .LOCKED(LOCKED)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // cyc = number of posedges since the last reset release; sampled on the falling edge.
  task automatic tick();
    @(negedge clk);
    cyc++;
  endtask

  task automatic drive_wr(input logic we, input int sel, input int d, input int h, input int p);
    cfg.cfg_we     = we;
    cfg.cfg_sel    = 3'(sel);
    cfg.cfg_divide = CNT_W'(d);
    cfg.cfg_high   = CNT_W'(h);
    cfg.cfg_phase  = CNT_W'(p);
  endtask

  task automatic test_reset();
    RST_N = 1'b0; PWRDWN = 1'b0; realign = 1'b0;
    drive_wr(1'b0, 0, 0, 0, 0);
    #2;
    total++;
    if (CLKOUT !== '0) begin bad++; $display("FAIL reset_clkout got=%b want=0", CLKOUT); end
    total++;
    if (LOCKED !== 1'b0) begin bad++; $display("FAIL reset_locked got=%b want=0", LOCKED); end
    total++;
    if (cfg.cfg_err !== 1'b0) begin bad++; $display("FAIL reset_err got=%b want=0", cfg.cfg_err); end
    repeat (3) @(negedge clk);
    RST_N = 1'b1;
    cyc = 0;
  endtask

  task automatic test_default_run();
    logic [NUM_OUT-1:0] exp_v;
    for (int k = 1; k <= 19; k++) begin
      tick();
      exp_v = (cyc % 2 == 1) ? '1 : '0;
      total++;
      if (CLKOUT !== exp_v) begin bad++; $display("FAIL default_clkout cyc=%0d got=%b want=%b", cyc, CLKOUT, exp_v); end
      total++;
      if (LOCKED !== (cyc >= 17)) begin bad++; $display("FAIL default_locked cyc=%0d got=%b want=%b", cyc, LOCKED, cyc >= 17); end
    end
  endtask

  task automatic test_reconfig();
    logic [NUM_OUT-1:0] exp_v;
    while (cyc < 40) begin
      if (cyc == 19) drive_wr(1'b1, 1, 5, 2, 0);
      else           drive_wr(1'b0, 0, 0, 0, 0);
      tick();
      exp_v    = (cyc % 2 == 1) ? '1 : '0;
      exp_v[1] = (cyc >= 21) && (((cyc - 21) % 5) < 2);
      total++;
      if (CLKOUT !== exp_v) begin bad++; $display("FAIL reconfig_clkout cyc=%0d got=%b want=%b", cyc, CLKOUT, exp_v); end
      total++;
      if (LOCKED !== (cyc >= 37)) begin bad++; $display("FAIL reconfig_locked cyc=%0d got=%b want=%b", cyc, LOCKED, cyc >= 37); end
    end
  endtask

  task automatic test_reject();
    logic [NUM_OUT-1:0] exp_v;
    while (cyc < 46) begin
      if (cyc == 40)      drive_wr(1'b1, 0, 5, 5, 0);
      else if (cyc == 42) drive_wr(1'b1, 7, 4, 2, 0);
      else                drive_wr(1'b0, 0, 0, 0, 0);
      tick();
      exp_v    = (cyc % 2 == 1) ? '1 : '0;
      exp_v[1] = ((cyc - 21) % 5) < 2;
      total++;
      if (cfg.cfg_err !== ((cyc == 41) || (cyc == 43))) begin
        bad++; $display("FAIL reject_err cyc=%0d got=%b want=%b", cyc, cfg.cfg_err, (cyc == 41) || (cyc == 43));
      end
      total++;
      if (CLKOUT !== exp_v) begin bad++; $display("FAIL reject_clkout cyc=%0d got=%b want=%b", cyc, CLKOUT, exp_v); end
      total++;
      if (LOCKED !== 1'b1) begin bad++; $display("FAIL reject_locked cyc=%0d got=%b want=1", cyc, LOCKED); end
    end
  endtask

  // After a start event at posedge 50+0 (realign) or 83+0 (power-up), m counts edges from it.
  task automatic test_realign();
    logic [NUM_OUT-1:0] exp_v;
    int m;
    drive_wr(1'b1, 2, 4, 2, 3);
    tick();
    total++;
    if (LOCKED !== 1'b0) begin bad++; $display("FAIL realign_wr_locked cyc=%0d got=%b want=0", cyc, LOCKED); end
    drive_wr(1'b1, 0, 4, 2, 0);
    tick();
    drive_wr(1'b0, 0, 0, 0, 0);
    realign = 1'b1;
    tick();
    realign = 1'b0;
    total++;
    if (CLKOUT !== '0) begin bad++; $display("FAIL realign_clear cyc=%0d got=%b want=0", cyc, CLKOUT); end
    while (cyc < 72) begin
      tick();
      m = cyc - 50;
      exp_v[0] = (m % 4) < 2;
      exp_v[1] = (m % 5) < 2;
      exp_v[2] = (m >= 3) && (((m - 3) % 4) < 2);
      exp_v[3] = (m % 2) == 0;
      exp_v[4] = (m % 2) == 0;
      total++;
      if (CLKOUT !== exp_v) begin bad++; $display("FAIL realign_clkout cyc=%0d got=%b want=%b", cyc, CLKOUT, exp_v); end
      total++;
      if (LOCKED !== (cyc >= 69)) begin bad++; $display("FAIL realign_locked cyc=%0d got=%b want=%b", cyc, LOCKED, cyc >= 69); end
    end
  endtask

  task automatic test_pwrdwn();
    logic [NUM_OUT-1:0] exp_v;
    int m;
    PWRDWN = 1'b1;
    while (cyc < 82) begin
      if (cyc == 74) drive_wr(1'b1, 3, 6, 3, 0);
      else           drive_wr(1'b0, 0, 0, 0, 0);
      tick();
      total++;
      if (CLKOUT !== '0) begin bad++; $display("FAIL pwrdwn_clkout cyc=%0d got=%b want=0", cyc, CLKOUT); end
      total++;
      if (LOCKED !== 1'b0) begin bad++; $display("FAIL pwrdwn_locked cyc=%0d got=%b want=0", cyc, LOCKED); end
    end
    PWRDWN = 1'b0;
    while (cyc < 103) begin
      tick();
      m = cyc - 83;
      exp_v[0] = (m % 4) < 2;
      exp_v[1] = (m % 5) < 2;
      exp_v[2] = (m >= 3) && (((m - 3) % 4) < 2);
      exp_v[3] = (m % 6) < 3;
      exp_v[4] = (m % 2) == 0;
      total++;
      if (CLKOUT !== exp_v) begin bad++; $display("FAIL powerup_clkout cyc=%0d got=%b want=%b", cyc, CLKOUT, exp_v); end
      total++;
      if (LOCKED !== (cyc >= 102)) begin bad++; $display("FAIL powerup_locked cyc=%0d got=%b want=%b", cyc, LOCKED, cyc >= 102); end
    end
  endtask

  task automatic test_async_reset();
    logic [NUM_OUT-1:0] exp_v;
    #2;
    RST_N = 1'b0;
    #1;
    total++;
    if (CLKOUT !== '0) begin bad++; $display("FAIL async_rst_clkout got=%b want=0", CLKOUT); end
    total++;
    if (LOCKED !== 1'b0) begin bad++; $display("FAIL async_rst_locked got=%b want=0", LOCKED); end
    repeat (2) @(negedge clk);
    RST_N = 1'b1;
    cyc = 0;
    for (int k = 1; k <= 4; k++) begin
      tick();
      exp_v = (cyc % 2 == 1) ? '1 : '0;
      total++;
      if (CLKOUT !== exp_v) begin bad++; $display("FAIL after_rst_clkout cyc=%0d got=%b want=%b", cyc, CLKOUT, exp_v); end
      total++;
      if (LOCKED !== 1'b0) begin bad++; $display("FAIL after_rst_locked cyc=%0d got=%b want=0", cyc, LOCKED); end
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    cyc   = 0;
    test_reset();
    test_default_run();
    test_reconfig();
    test_reject();
    test_realign();
    test_pwrdwn();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
